// File: rtl/rps_round_ctrl.sv
// rps_round_ctrl
// Round sequencer for rock-paper-scissors. It takes the player's move, draws a
// CPU move from the 2-bit random source (re-drawing while the source shows the
// unusable code 11), judges the round, and updates both scores. It then holds
// the result for a fixed reveal period. The match ends once either score
// reaches WIN_TARGET.
//
// Ports
//   Clk, Reset      : rising-edge clock, synchronous active-high reset
//   Start           : begins a match from INI, or a new match from DONE
//   Player_Valid    : qualifies Player_Move for one cycle
//   Player_Move[1:0]: 00 rock, 01 paper, 10 scissors, 11 invalid
//   Rnd[1:0]        : random source, same encoding, 11 unusable
//   Player_Latched  : player move of the current round
//   Cpu_Move        : CPU move of the current round
//   Result[1:0]     : 00 none, 01 player wins, 10 CPU wins, 11 tie
//   Player_Score    : player round wins this match
//   Cpu_Score       : CPU round wins this match
//   Match_Over      : high in DONE
//   Match_Winner    : 0 player, 1 CPU (meaningful while Match_Over)
//   q_*             : one-hot state flags, exposed for debug and checkers
//
// Handshake: Player_Valid has no ready partner. A move is consumed on the
// rising edge where the block is in WAIT, Player_Valid=1 and
// Player_Move!=11. It is dropped silently in every other case, so the
// upstream debouncer simply pulses and the move either lands or is ignored.
module rps_round_ctrl #(
  parameter int WIN_TARGET    = 3,
  parameter int REVEAL_CYCLES = 25_000_000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Player_Valid,
  input  logic [1:0] Player_Move,
  input  logic [1:0] Rnd,
  output logic [1:0] Player_Latched,
  output logic [1:0] Cpu_Move,
  output logic [1:0] Result,
  output logic [3:0] Player_Score,
  output logic [3:0] Cpu_Score,
  output logic       Match_Over,
  output logic       Match_Winner,
  output logic       q_Ini,
  output logic       q_Wait,
  output logic       q_Draw,
  output logic       q_Judge,
  output logic       q_Reveal,
  output logic       q_Done
);

  localparam int CW = $clog2(REVEAL_CYCLES) + 1;
  localparam logic [3:0]    TARGET    = 4'(WIN_TARGET);
  localparam logic [CW-1:0] CNT_START = CW'(REVEAL_CYCLES - 1);

  typedef enum logic [5:0] {
    S_INI    = 6'b000001,
    S_WAIT   = 6'b000010,
    S_DRAW   = 6'b000100,
    S_JUDGE  = 6'b001000,
    S_REVEAL = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    pl_q, pl_d;
  logic [1:0]    cm_q, cm_d;
  logic [1:0]    res_q, res_d;
  logic [3:0]    ps_q, ps_d;
  logic [3:0]    cs_q, cs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cm_plus1;

  // The move that beats the CPU move, i.e. (player - cpu) mod 3 == 1.
  assign cm_plus1 = (cm_q == 2'd2) ? 2'd0 : cm_q + 2'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INI;
      pl_q    <= '0;
      cm_q    <= '0;
      res_q   <= '0;
      ps_q    <= '0;
      cs_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pl_q    <= pl_d;
      cm_q    <= cm_d;
      res_q   <= res_d;
      ps_q    <= ps_d;
      cs_q    <= cs_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pl_d    = pl_q;
    cm_d    = cm_q;
    res_d   = res_q;
    ps_d    = ps_q;
    cs_d    = cs_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INI: begin
        if (Start) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (Player_Valid && (Player_Move != 2'b11)) begin
          pl_d    = Player_Move;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        // Code 11 is unusable: stay and take the next sample.
        if (Rnd != 2'b11) begin
          cm_d    = Rnd;
          state_d = S_JUDGE;
        end
      end
      S_JUDGE: begin
        if (pl_q == cm_q) begin
          res_d = 2'b11;
        end else if (pl_q == cm_plus1) begin
          res_d = 2'b01;
          if (ps_q != TARGET) ps_d = ps_q + 4'd1;
        end else begin
          res_d = 2'b10;
          if (cs_q != TARGET) cs_d = cs_q + 4'd1;
        end
        cnt_d   = CNT_START;
        state_d = S_REVEAL;
      end
      S_REVEAL: begin
        if (cnt_q == '0) begin
          if ((ps_q == TARGET) || (cs_q == TARGET)) state_d = S_DONE;
          else                                      state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        if (Start) begin
          pl_d    = '0;
          cm_d    = '0;
          res_d   = '0;
          ps_d    = '0;
          cs_d    = '0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_INI;
    endcase
  end

  assign Player_Latched = pl_q;
  assign Cpu_Move       = cm_q;
  assign Result         = res_q;
  assign Player_Score   = ps_q;
  assign Cpu_Score      = cs_q;
  assign q_Ini          = state_q[0];
  assign q_Wait         = state_q[1];
  assign q_Draw         = state_q[2];
  assign q_Judge        = state_q[3];
  assign q_Reveal       = state_q[4];
  assign q_Done         = state_q[5];
  assign Match_Over     = q_Done;
  // Only one score moves per round, so reaching the target identifies the winner.
  assign Match_Winner   = q_Done && (cs_q == TARGET);

endmodule
